// File: rtl/xbar_arb.sv
// Per-output round-robin arbiter feeding a crossbar mux select field.
// Each output owns at most one source; ownership is held until release or hold-limit preemption.
module xbar_arb #(
  parameter int N_IN     = 5,
  parameter int N_OUT    = 5,
  parameter int MAX_HOLD = 16
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic                               i_cg,
  input  logic [N_IN-1:0]                    i_req,
  input  logic [N_IN*$clog2(N_OUT)-1:0]      i_dst,
  output logic [N_IN-1:0]                    o_grant,
  output logic [N_OUT*$clog2(N_IN)-1:0]      o_select,
  output logic [N_OUT-1:0]                   o_active
);

  localparam int IW = $clog2(N_IN);
  localparam int DW = $clog2(N_OUT);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_OWNED} st_t;

  st_t               r_st     [N_OUT];
  logic [IW-1:0]     r_owner  [N_OUT];
  logic [IW-1:0]     r_ptr    [N_OUT];
  logic [HW-1:0]     r_hold   [N_OUT];
  logic [N_IN-1:0]   r_grant;

  st_t               w_st_nxt    [N_OUT];
  logic [IW-1:0]     w_owner_nxt [N_OUT];
  logic [IW-1:0]     w_ptr_nxt   [N_OUT];
  logic [HW-1:0]     w_hold_nxt  [N_OUT];
  logic [N_IN-1:0]   w_cand      [N_OUT];
  logic [N_IN-1:0]   w_grant_nxt;

  // Candidate matrix: out-of-range destinations never equal any valid j.
  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      w_cand[j] = '0;
      for (int i = 0; i < N_IN; i++) begin
        w_cand[j][i] = i_req[i] && (i_dst[i*DW +: DW] == DW'(j));
      end
    end
  end

  always_comb begin
    logic [N_IN-1:0] w_others;
    logic            w_found;
    logic            w_keep;
    logic            w_preempt;
    int              w_idx;
    w_grant_nxt = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_st_nxt[j]    = r_st[j];
      w_owner_nxt[j] = r_owner[j];
      w_ptr_nxt[j]   = r_ptr[j];
      w_hold_nxt[j]  = r_hold[j];
      w_others       = w_cand[j];
      w_others[r_owner[j]] = 1'b0;
      w_keep         = w_cand[j][r_owner[j]];
      w_preempt      = (MAX_HOLD != 0) && (r_hold[j] == HOLD_LAST) && (|w_others);
      w_found        = 1'b0;
      case (r_st[j])
        S_IDLE: begin
          if (|w_cand[j]) begin
            // Search starts one past the last owner and wraps modulo N_IN.
            for (int k = 1; k <= N_IN; k++) begin
              w_idx = int'(r_ptr[j]) + k;
              if (w_idx >= N_IN) w_idx = w_idx - N_IN;
              if (!w_found && w_cand[j][w_idx]) begin
                w_found        = 1'b1;
                w_owner_nxt[j] = IW'(w_idx);
              end
            end
            w_st_nxt[j]   = S_OWNED;
            w_hold_nxt[j] = '0;
          end
        end
        S_OWNED: begin
          if (!w_keep || w_preempt) begin
            w_st_nxt[j]  = S_IDLE;
            w_ptr_nxt[j] = r_owner[j];
          end else if ((MAX_HOLD != 0) && (r_hold[j] != HOLD_LAST)) begin
            w_hold_nxt[j] = r_hold[j] + 1'b1;
          end
        end
        default: w_st_nxt[j] = S_IDLE;
      endcase
      if (w_st_nxt[j] == S_OWNED) w_grant_nxt[w_owner_nxt[j]] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_st[j]    <= S_IDLE;
        r_owner[j] <= '0;
        r_ptr[j]   <= IW'(N_IN - 1);
        r_hold[j]  <= '0;
      end
      r_grant <= '0;
    end else if (i_cg) begin
      for (int j = 0; j < N_OUT; j++) begin
        r_st[j]    <= w_st_nxt[j];
        r_owner[j] <= w_owner_nxt[j];
        r_ptr[j]   <= w_ptr_nxt[j];
        r_hold[j]  <= w_hold_nxt[j];
      end
      r_grant <= w_grant_nxt;
    end
  end

  // Select holds the last owner while idle; consumers qualify with o_active.
  always_comb begin
    o_select = '0;
    o_active = '0;
    for (int j = 0; j < N_OUT; j++) begin
      o_select[j*IW +: IW] = r_owner[j];
      o_active[j]          = (r_st[j] == S_OWNED);
    end
  end

  assign o_grant = r_grant;

endmodule

// File: tb/tb_xbar_arb.sv
// Directed bench for xbar_arb (N_IN=5, N_OUT=5, MAX_HOLD=4) with hand-computed expectations.
module tb_xbar_arb;

  localparam int N_IN  = 5;
  localparam int N_OUT = 5;
  localparam int IW    = 3;
  localparam int DW    = 3;

  logic                    clk;
  logic                    rst_n;
  logic                    cg;
  logic [N_IN-1:0]         req;
  logic [N_IN*DW-1:0]      dst;
  logic [N_IN-1:0]         grant;
  logic [N_OUT*IW-1:0]     sel;
  logic [N_OUT-1:0]        active;

  int n_checks;
  int n_errors;

  xbar_arb #(.N_IN(N_IN), .N_OUT(N_OUT), .MAX_HOLD(4)) u_dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_cg     (cg),
    .i_req    (req),
    .i_dst    (dst),
    .o_grant  (grant),
    .o_select (sel),
    .o_active (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dst(input int i, input int v);
    dst[i*DW +: DW] = DW'(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cg    = 1'b1;
    req   = '0;
    dst   = '0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    cg    = 1'b1;
    req   = '0;
    dst   = '0;

    // Reset state
    do_reset();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_select", 32'(sel), 32'h0);

    // Lone source 0 to output 2, held
    req = 5'b00001;
    set_dst(0, 2);
    step();
    chk("t1_grant", 32'(grant), 32'h01);
    chk("t1_active", 32'(active), 32'h04);
    chk("t1_select", 32'(sel), 32'h0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("t1_hold_grant", 32'(grant), 32'h01);
    end
    req = '0;
    step();
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_rel_active", 32'(active), 32'h0);

    // Sources 1 and 3 contend for output 0
    do_reset();
    req = 5'b01010;
    set_dst(1, 0);
    set_dst(3, 0);
    step();
    chk("t2_grant1", 32'(grant), 32'h02);
    chk("t2_sel1", 32'(sel), 32'h1);
    req = 5'b01000;
    step();
    chk("t2_bubble_active", 32'(active), 32'h0);
    chk("t2_bubble_grant", 32'(grant), 32'h0);
    chk("t2_bubble_sel", 32'(sel), 32'h1);
    step();
    chk("t2_grant3", 32'(grant), 32'h08);
    chk("t2_sel3", 32'(sel), 32'h3);
    chk("t2_active3", 32'(active), 32'h01);

    // Preemption at hold limit 4 on output 1
    do_reset();
    req = 5'b00101;
    set_dst(0, 1);
    set_dst(2, 1);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("t3_own0", 32'(grant), 32'h01);
    end
    step();
    chk("t3_preempt_active", 32'(active), 32'h0);
    chk("t3_preempt_grant", 32'(grant), 32'h0);
    step();
    chk("t3_own2", 32'(grant), 32'h04);
    chk("t3_sel2", 32'(sel), 32'(2 << 3));
    step();
    chk("t3_own2b", 32'(grant), 32'h04);
    req = 5'b00001;
    step();
    chk("t3_rel2", 32'(grant), 32'h0);
    step();
    chk("t3_regrant0", 32'(grant), 32'h01);
    chk("t3_regrant0_sel", 32'(sel), 32'h0);

    // Lone requester is never preempted
    do_reset();
    req = 5'b00100;
    set_dst(2, 3);
    for (int c = 0; c < 100; c++) begin
      step();
      chk("t4_lone_grant", 32'(grant), 32'h04);
    end
    chk("t4_lone_active", 32'(active), 32'h08);

    // Clock gate holds state; out-of-range destination ignored
    do_reset();
    cg  = 1'b0;
    req = 5'b00010;
    set_dst(1, 4);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_cg_grant", 32'(grant), 32'h0);
    end
    cg = 1'b1;
    step();
    chk("t5_cg_on_grant", 32'(grant), 32'h02);
    chk("t5_cg_on_active", 32'(active), 32'h10);
    chk("t5_cg_on_sel", 32'(sel), 32'(1 << 12));
    req = '0;
    step();
    chk("t5_rel", 32'(grant), 32'h0);
    req = 5'b00010;
    set_dst(1, 7);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("t5_oor_grant", 32'(grant), 32'h0);
      chk("t5_oor_active", 32'(active), 32'h0);
    end

    // Reset mid-ownership with gate off
    do_reset();
    req = 5'b00011;
    set_dst(0, 0);
    set_dst(1, 3);
    step();
    chk("t6_grant", 32'(grant), 32'h03);
    chk("t6_active", 32'(active), 32'h09);
    chk("t6_sel", 32'(sel), 32'(1 << 9));
    rst_n = 1'b0;
    cg    = 1'b0;
    step();
    chk("t6_rst_grant", 32'(grant), 32'h0);
    chk("t6_rst_active", 32'(active), 32'h0);
    chk("t6_rst_sel", 32'(sel), 32'h0);
    rst_n = 1'b1;
    cg    = 1'b1;
    req   = 5'b10001;
    set_dst(0, 0);
    set_dst(4, 0);
    step();
    chk("t6_post_grant", 32'(grant), 32'h01);
    chk("t6_post_sel", 32'(sel), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
